axi_lite_manager: RTL and testbench

//  AXI4-Lite manager (initiator): turns single-beat commands from a simple valid/ready port into
//  AXI4-Lite read/write transactions. Issues register accesses to the ADC-side AXI4-Lite

---
 rtl/axi_lite_manager_pkg.sv | 18 +
 rtl/axi_lite_manager.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_lite_manager.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_manager_pkg.sv
// Shared encodings for the AXI4-Lite manager: response codes, FSM states and
// the word-alignment helper used when a command is accepted.
package axi_lite_manager_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WADDR_DATA = 3'd1;
  localparam logic [2:0] ST_WRESP      = 3'd2;
  localparam logic [2:0] ST_RADDR      = 3'd3;
  localparam logic [2:0] ST_RDATA      = 3'd4;
  localparam logic [2:0] ST_RESP       = 3'd5;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/axi_lite_manager.sv
// AXI4-Lite manager: one single-beat command at a time from a valid/ready port,
// with a watchdog that flags subordinates which stall. All outputs are registered.
module axi_lite_manager
  import axi_lite_manager_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [2:0]  AXI_PROT       = 3'b000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        timeout,
  output logic [31:0] m_axi_lite_awaddr,
  output logic [2:0]  m_axi_lite_awprot,
  output logic        m_axi_lite_awvalid,
  input  logic        m_axi_lite_awready,
  output logic [31:0] m_axi_lite_wdata,
  output logic [3:0]  m_axi_lite_wstrb,
  output logic        m_axi_lite_wvalid,
  input  logic        m_axi_lite_wready,
  input  logic [1:0]  m_axi_lite_bresp,
  input  logic        m_axi_lite_bvalid,
  output logic        m_axi_lite_bready,
  output logic [31:0] m_axi_lite_araddr,
  output logic [2:0]  m_axi_lite_arprot,
  output logic        m_axi_lite_arvalid,
  input  logic        m_axi_lite_arready,
  input  logic [31:0] m_axi_lite_rdata,
  input  logic [1:0]  m_axi_lite_rresp,
  input  logic        m_axi_lite_rvalid,
  output logic        m_axi_lite_rready
);

  logic [2:0]  state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  rsp_resp_q, rsp_resp_d;
  logic        accept, rsp_hs, aw_hs, w_hs;

  assign accept = (state_q == ST_IDLE) && cmd_valid && cmd_ready_q;
  assign rsp_hs = (state_q == ST_RESP) && rsp_valid_q && rsp_ready;
  assign aw_hs  = awvalid_q && m_axi_lite_awready;
  assign w_hs   = wvalid_q && m_axi_lite_wready;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    case (state_q)
      ST_IDLE: begin
        // cmd_ready comes up on the first edge after reset and stays up until a command lands
        cmd_ready_d = 1'b1;
        if (accept) begin
          cmd_ready_d = 1'b0;
          addr_d      = align_word(cmd_addr);
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            state_d   = ST_WADDR_DATA;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end else begin
            state_d   = ST_RADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      ST_WADDR_DATA: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d  = ST_WRESP;
          bready_d = 1'b1;
        end
      end
      ST_WRESP: begin
        if (m_axi_lite_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_resp_d  = m_axi_lite_bresp;
          state_d     = ST_RESP;
        end
      end
      ST_RADDR: begin
        if (arvalid_q && m_axi_lite_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (m_axi_lite_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = m_axi_lite_rdata;
          rsp_resp_d  = m_axi_lite_rresp;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_hs) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      rsp_rdata_q <= 32'h0;
      rsp_resp_q  <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Watchdog: counts stalled cycles only while an AXI channel is outstanding; never aborts
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_wd
      assign timeout = 1'b0;
    end else begin : g_wd
      localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);
      logic [31:0] wd_cnt_q, wd_cnt_d;
      logic        timeout_q, timeout_d;
      logic        busy;

      assign busy = (state_q != ST_IDLE) && (state_q != ST_RESP);

      always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if (accept) begin
          wd_cnt_d  = 32'h0;
          timeout_d = 1'b0;
        end else if (rsp_hs) begin
          timeout_d = 1'b0;
        end else if (busy && (wd_cnt_q != TO_LIMIT)) begin
          wd_cnt_d  = wd_cnt_q + 32'd1;
          timeout_d = (wd_cnt_d == TO_LIMIT);
        end
      end

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          wd_cnt_q  <= 32'h0;
          timeout_q <= 1'b0;
        end else begin
          wd_cnt_q  <= wd_cnt_d;
          timeout_q <= timeout_d;
        end
      end

      assign timeout = timeout_q;
    end
  endgenerate

  assign cmd_ready          = cmd_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_rdata          = rsp_rdata_q;
  assign rsp_resp           = rsp_resp_q;
  assign m_axi_lite_awaddr  = addr_q;
  assign m_axi_lite_awprot  = AXI_PROT;
  assign m_axi_lite_awvalid = awvalid_q;
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_wstrb   = wstrb_q;
  assign m_axi_lite_wvalid  = wvalid_q;
  assign m_axi_lite_bready  = bready_q;
  assign m_axi_lite_araddr  = addr_q;
  assign m_axi_lite_arprot  = AXI_PROT;
  assign m_axi_lite_arvalid = arvalid_q;
  assign m_axi_lite_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_manager.sv
// Bench for axi_lite_manager: table of transactions against a delay-configurable
// subordinate, plus a hand-written asynchronous reset sequence.
module tb_axi_lite_manager;

  localparam int         TOUT    = 8;
  localparam logic [2:0] TB_PROT = 3'b010;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  int checks = 0;
  int errors = 0;

  axi_lite_manager #(.TIMEOUT_CYCLES(TOUT), .AXI_PROT(TB_PROT)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .timeout(timeout),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awprot(awprot),
    .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb),
    .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
    .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
    .m_axi_lite_araddr(araddr), .m_axi_lite_arprot(arprot),
    .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
    .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
    .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    string       name;
    logic        wr;
    logic [31:0] addr, wd;
    logic [3:0]  strb;
    int          aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
    logic [1:0]  resp;
    logic [31:0] sub_rdata;
    logic [31:0] exp_addr, exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mk(input string nm, input logic wr, input logic [31:0] a, d,
                              input logic [3:0] s, input int awd, wd_, bd, ard, rd, rspd,
                              input logic [1:0] rs, input logic [31:0] srd, ea, erd,
                              input logic [1:0] ers, input int lat, input logic eto);
    vec_t v;
    v.name = nm; v.wr = wr; v.addr = a; v.wd = d; v.strb = s;
    v.aw_dly = awd; v.w_dly = wd_; v.b_dly = bd; v.ar_dly = ard; v.r_dly = rd;
    v.rsp_dly = rspd; v.resp = rs; v.sub_rdata = srd; v.exp_addr = ea;
    v.exp_rdata = erd; v.exp_resp = ers; v.exp_lat = lat; v.exp_to = eto;
    return v;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle_sub();
    awready = 0; wready = 0; bvalid = 0; bresp = 2'b00;
    arready = 0; rvalid = 0; rresp = 2'b00; rdata = 32'hBAD0_BAD0;
    rsp_ready = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int n, lat, busy;
    int aw_hs, w_hs, b_hs, ar_hs, r_hs;
    int aw_w, w_w, b_w, ar_w, r_w, rs_w;
    bit done, seen, addr_ok, data_ok, crdy_ok, stable_ok, to_ok, vld_ok;
    logic [31:0] rd0;
    logic [1:0]  rr0;
    logic        to0;
    lat = 0; busy = 0; aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    aw_w = 0; w_w = 0; b_w = 0; ar_w = 0; r_w = 0; rs_w = 0;
    done = 0; seen = 0; addr_ok = 1; data_ok = 1; crdy_ok = 1; stable_ok = 1;
    to_ok = 1; vld_ok = 1; rd0 = 0; rr0 = 0; to0 = 0;
    n = 0;
    while (!cmd_ready && n < 10) begin tick(); n++; end
    chk({v.name, " cmd_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wd; cmd_wstrb = v.strb;
    tick();
    // keep junk on the command port while busy; it must be ignored
    cmd_write = ~v.wr; cmd_addr = 32'hDEAD_BEE0; cmd_wdata = 32'h5A5A_5A5A; cmd_wstrb = ~v.strb;
    for (int t = 1; t <= 60 && !done; t++) begin
      if (cmd_ready !== 1'b0) crdy_ok = 0;
      if (timeout !== (busy >= TOUT)) to_ok = 0;
      rsp_ready = 0;
      if (rsp_valid) begin
        if (!seen) begin
          seen = 1; lat = t; rd0 = rsp_rdata; rr0 = rsp_resp; to0 = timeout;
        end else if (rsp_rdata !== rd0 || rsp_resp !== rr0) stable_ok = 0;
        if (rs_w >= v.rsp_dly) begin rsp_ready = 1; cmd_valid = 0; done = 1; end
        rs_w++;
      end else busy++;
      bvalid = 0;
      if (aw_hs > 0 && w_hs > 0 && b_hs == 0) begin
        if (b_w >= v.b_dly) begin
          bvalid = 1; bresp = v.resp;
          if (bready) b_hs++;
        end
        b_w++;
      end
      rvalid = 0; rdata = 32'hBAD0_BAD0;
      if (ar_hs > 0 && r_hs == 0) begin
        if (r_w >= v.r_dly) begin
          rvalid = 1; rdata = v.sub_rdata; rresp = v.resp;
          if (rready) r_hs++;
        end
        r_w++;
      end
      if (v.wr && aw_hs == 0 && !awvalid) vld_ok = 0;
      if (v.wr && w_hs == 0 && !wvalid) vld_ok = 0;
      if (!v.wr && ar_hs == 0 && !arvalid) vld_ok = 0;
      awready = 0;
      if (awvalid) begin
        if (awaddr !== v.exp_addr || awprot !== TB_PROT) addr_ok = 0;
        if (aw_w >= v.aw_dly) begin awready = 1; aw_hs++; end
        aw_w++;
      end
      wready = 0;
      if (wvalid) begin
        if (wdata !== v.wd || wstrb !== v.strb) data_ok = 0;
        if (w_w >= v.w_dly) begin wready = 1; w_hs++; end
        w_w++;
      end
      arready = 0;
      if (arvalid) begin
        if (araddr !== v.exp_addr || arprot !== TB_PROT) addr_ok = 0;
        if (ar_w >= v.ar_dly) begin arready = 1; ar_hs++; end
        ar_w++;
      end
      tick();
    end
    idle_sub();
    cmd_valid = 0;
    chk({v.name, " rsp_handshake"}, 32'(done), 32'd1);
    chk({v.name, " rsp_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, " rsp_rdata"}, rd0, v.exp_rdata);
    chk({v.name, " rsp_resp"}, 32'(rr0), 32'(v.exp_resp));
    chk({v.name, " timeout_at_rsp"}, 32'(to0), 32'(v.exp_to));
    chk({v.name, " aw_count"}, 32'(aw_hs), v.wr ? 32'd1 : 32'd0);
    chk({v.name, " w_count"}, 32'(w_hs), v.wr ? 32'd1 : 32'd0);
    chk({v.name, " b_count"}, 32'(b_hs), v.wr ? 32'd1 : 32'd0);
    chk({v.name, " ar_count"}, 32'(ar_hs), v.wr ? 32'd0 : 32'd1);
    chk({v.name, " r_count"}, 32'(r_hs), v.wr ? 32'd0 : 32'd1);
    chk({v.name, " addr_prot_stable"}, 32'(addr_ok), 32'd1);
    chk({v.name, " wdata_strb_stable"}, 32'(data_ok), 32'd1);
    chk({v.name, " valid_held"}, 32'(vld_ok), 32'd1);
    chk({v.name, " cmd_ready_low_busy"}, 32'(crdy_ok), 32'd1);
    chk({v.name, " rsp_stable"}, 32'(stable_ok), 32'd1);
    chk({v.name, " timeout_per_cycle"}, 32'(to_ok), 32'd1);
    chk({v.name, " after_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({v.name, " after_timeout"}, 32'(timeout), 32'd0);
    chk({v.name, " after_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    //            name        wr   addr          wdata         strb aw w  b  ar r  rsp resp   sub_rdata     exp_addr      exp_rdata     eresp  lat to
    vecs[0] = mk("wr_zero",   1'b1, 32'h0000_0100, 32'h0000_0003, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,         32'h0000_0100, 32'h0,         2'b00, 3,  1'b0);
    vecs[1] = mk("wr_aw_first",1'b1,32'h0000_0107, 32'h0000_0010, 4'h3, 0, 3, 0, 0, 0, 0, 2'b00, 32'h0,         32'h0000_0104, 32'h0,         2'b00, 6,  1'b0);
    vecs[2] = mk("rd_slow_r", 1'b0, 32'h0000_0104, 32'h0,         4'h0, 0, 0, 0, 0, 4, 0, 2'b00, 32'h0000_00FF, 32'h0000_0104, 32'h0000_00FF, 2'b00, 7,  1'b0);
    vecs[3] = mk("rd_slverr", 1'b0, 32'h0000_0200, 32'h0,         4'h0, 0, 0, 0, 0, 0, 4, 2'b10, 32'h1234_5678, 32'h0000_0200, 32'h1234_5678, 2'b10, 3,  1'b0);
    vecs[4] = mk("wr_timeout",1'b1, 32'h0000_0100, 32'h0000_00A5, 4'hF, 20,0, 0, 0, 0, 0, 2'b00, 32'h0,         32'h0000_0100, 32'h0,         2'b00, 23, 1'b1);
    vecs[5] = mk("wr_decerr", 1'b1, 32'h0000_010C, 32'hCAFE_F00D, 4'h5, 2, 0, 2, 0, 0, 1, 2'b11, 32'h0,         32'h0000_010C, 32'h0,         2'b11, 7,  1'b0);
    vecs[6] = mk("rd_exokay", 1'b0, 32'h0000_0FF3, 32'h0,         4'h0, 0, 0, 0, 2, 1, 0, 2'b01, 32'h8000_0001, 32'h0000_0FF0, 32'h8000_0001, 2'b01, 6,  1'b0);

    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    idle_sub();
    aresetn = 1;
    #1 aresetn = 0;
    #2;
    chk("reset_valids", {28'h0, awvalid, wvalid, arvalid, rsp_valid}, 32'h0);
    chk("reset_readies", {29'h0, cmd_ready, bready, rready}, 32'h0);
    chk("reset_rsp", {rsp_rdata[29:0], rsp_resp}, 32'h0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    tick(); tick();
    aresetn = 1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset in the middle of a write with wvalid high
    begin
      int n;
      n = 0;
      while (!cmd_ready && n < 10) begin tick(); n++; end
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h0000_0104; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
      tick();
      cmd_valid = 0;
      tick();
      chk("midreset_wvalid_before", 32'(wvalid), 32'd1);
      chk("midreset_awvalid_before", 32'(awvalid), 32'd1);
      #2 aresetn = 0;
      #1;
      chk("midreset_valids_async", {28'h0, awvalid, wvalid, arvalid, rsp_valid}, 32'h0);
      chk("midreset_readies_async", {29'h0, cmd_ready, bready, rready}, 32'h0);
      tick(); tick();
      chk("midreset_no_rsp", 32'(rsp_valid), 32'd0);
      aresetn = 1;
      tick();
      chk("midreset_rsp_still_idle", 32'(rsp_valid), 32'd0);
    end
    vecs[0].name = "post_reset_wr";
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
